// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, frame levels and defaults.
// Used by uart_tx and uart_baud_gen (and the matching receiver).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int unsigned UART_DATA_BITS    = 8;
   localparam int unsigned UART_CLKS_PER_BIT = 8;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;
   localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte valid/ready handshake between a producer and the UART transmitter.
// master = producer, slave = uart_tx.
interface uart_tx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] data;
   logic                      valid;
   logic                      ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// pre_tick flags the cycle before bit_tick so callers can register edge outputs.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
   localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

   logic [W-1:0] cnt;

   assign bit_tick = enable && (cnt == LAST);
   assign pre_tick = enable && (cnt == PRE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= bit_tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, valid/ready byte input, LSB-first serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
   input  logic   clock,
   input  logic   reset,
   uart_tx_if.slave tx,
   output logic   out,
   output logic   busy,
   output logic   done
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   tx_state_t            state;
   logic [DATA_BITS-1:0] shift;
   logic [BW-1:0]        bit_cnt;
   logic                 ready;
   logic                 tick;
   logic                 pre_tick;
   logic                 hs;
`ifdef UART_TX_PARITY_EN
   logic                 parity;
`endif

   assign hs       = tx.valid & ready;
   assign tx.ready = ready;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock    (clock),
      .reset    (reset),
      .clear    (state == IDLE),
      .enable   (busy),
      .bit_tick (tick),
      .pre_tick (pre_tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shift   <= '0;
         bit_cnt <= '0;
         out     <= UART_IDLE_LEVEL;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (1'b1)
            (state == IDLE): begin
               if (hs) begin
                  shift <= tx.data;
                  state <= START;
                  out   <= UART_START_LEVEL;
                  ready <= 1'b0;
                  busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  parity <= ^tx.data;
`endif
               end
            end
            (state == START): begin
               if (tick) begin
                  state   <= DATA;
                  out     <= shift[0];
                  bit_cnt <= '0;
               end
            end
            (state == DATA): begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     out   <= parity;
`else
                     state <= STOP;
                     out   <= UART_STOP_LEVEL;
`endif
                  end else begin
                     shift   <= shift >> 1;
                     out     <= shift[1];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            (state == PARITY): begin
               if (tick) begin
                  state <= STOP;
                  out   <= UART_STOP_LEVEL;
               end
            end
`endif
            (state == STOP): begin
               // Raise done/ready so they are high in the last stop cycle.
               if (pre_tick) begin
                  done  <= 1'b1;
                  ready <= 1'b1;
               end
               if (tick) begin
                  if (hs) begin
                     shift <= tx.data;
                     state <= START;
                     out   <= UART_START_LEVEL;
                     ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
                     parity <= ^tx.data;
`endif
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               out   <= UART_IDLE_LEVEL;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (CLKS_PER_BIT = 8).
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int N = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * N;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic out;
   logic busy;
   logic done;

   uart_tx_if bus ();

   uart_tx #(
      .CLKS_PER_BIT(N)
   ) dut (
      .clock (clock),
      .reset (reset),
      .tx    (bus),
      .out   (out),
      .busy  (busy),
      .done  (done)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   logic [511:0] ow, dw, rw, bw;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic smp(input int k);
      ow[k] = out;
      dw[k] = done;
      rw[k] = bus.ready;
      bw[k] = busy;
   endtask

   function automatic logic [511:0] mask(input int n);
      return (512'(1) << n) - 512'(1);
   endfunction

   function automatic logic [511:0] bit_at(input int k);
      return 512'(1) << k;
   endfunction

   // Frame bits, bit 0 = start bit; p is the hand-computed parity bit.
   function automatic logic [10:0] fr(input logic [7:0] b, input logic p);
      logic [10:0] f;
      f = {1'b1, p, b, 1'b0};
`ifndef UART_TX_PARITY_EN
      f = {2'b01, b, 1'b0};
`endif
      return f;
   endfunction

   function automatic logic [511:0] ex(input logic [32:0] f, input int nb);
      logic [511:0] e;
      e = '0;
      for (int i = 0; i < nb * N; i++) e[i] = f[i / N];
      return e;
   endfunction

   task automatic idle_chk(input string tag);
      chk(tag, {508'd0, out, bus.ready, busy, done}, 512'b1100);
   endtask

   task automatic send(input string tag, input logic [7:0] b, input logic p);
      bus.valid = 1'b1;
      bus.data  = b;
      step();
      bus.valid = 1'b0;
      ow = '0; dw = '0; rw = '0; bw = '0;
      for (int k = 0; k < FL; k++) begin
         smp(k);
         if (k < FL - 1) step();
      end
      chk({tag, "_out"}, ow, ex(33'(fr(b, p)), NB));
      chk({tag, "_done"}, dw, bit_at(FL - 1));
      chk({tag, "_ready"}, rw, bit_at(FL - 1));
      chk({tag, "_busy"}, bw, mask(FL));
      step();
      idle_chk({tag, "_after"});
   endtask

   initial begin
      #400000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [32:0] f3;
      bus.valid = 1'b0;
      bus.data  = 8'h00;
      repeat (3) step();
      idle_chk("in_reset");
      reset = 1'b1;

      ow = '0; dw = '0; rw = '0; bw = '0;
      for (int k = 0; k < 50; k++) begin
         step();
         smp(k);
      end
      chk("idle_out", ow, mask(50));
      chk("idle_ready", rw, mask(50));
      chk("idle_busy", bw, '0);
      chk("idle_done", dw, '0);

      send("f55", 8'h55, 1'b0);
      send("f07", 8'h07, 1'b1);

      // Three frames back to back with valid held high.
      bus.valid = 1'b1;
      bus.data  = 8'hCC;
      step();
      bus.data = 8'hFF;
      ow = '0; dw = '0; rw = '0; bw = '0;
      for (int k = 0; k < 3 * FL; k++) begin
         smp(k);
         if (k == FL) bus.data = 8'h33;
         if (k == 2 * FL) bus.valid = 1'b0;
         if (k < 3 * FL - 1) step();
      end
      f3 = 33'(fr(8'hCC, 1'b0))
         | (33'(fr(8'hFF, 1'b0)) << NB)
         | (33'(fr(8'h33, 1'b0)) << (2 * NB));
      chk("b2b_out", ow, ex(f3, 3 * NB));
      chk("b2b_busy", bw, mask(3 * FL));
      chk("b2b_done", dw, bit_at(FL - 1) | bit_at(2 * FL - 1) | bit_at(3 * FL - 1));
      chk("b2b_ready", rw, bit_at(FL - 1) | bit_at(2 * FL - 1) | bit_at(3 * FL - 1));
      step();
      idle_chk("b2b_after");

      // Data toggles under valid=1 mid-frame; line must carry 0xA5.
      bus.valid = 1'b1;
      bus.data  = 8'hA5;
      step();
      ow = '0; dw = '0; rw = '0; bw = '0;
      for (int k = 0; k < FL; k++) begin
         smp(k);
         bus.data  = k[0] ? 8'h00 : 8'hFF;
         bus.valid = (k < FL - 2);
         if (k < FL - 1) step();
      end
      chk("tog_out", ow, ex(33'(fr(8'hA5, 1'b0)), NB));
      chk("tog_ready", rw, bit_at(FL - 1));
      chk("tog_done", dw, bit_at(FL - 1));
      step();
      idle_chk("tog_after");

      // Reset at cycle 35 of a 0x0F frame.
      bus.valid = 1'b1;
      bus.data  = 8'h0F;
      step();
      bus.valid = 1'b0;
      repeat (35) step();
      chk("mid_busy", {511'd0, busy}, 512'd1);
      #2;
      reset = 1'b0;
      #1;
      idle_chk("mid_reset");
      repeat (2) step();
      reset = 1'b1;
      send("f3C", 8'h3C, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the partner of the existing UART receiver on the same serial line.
- Accepts one byte per valid/ready handshake.
- Serialises each byte as start bit (0), 8 data bits LSB-first, stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles. Its `out` drives the receiver's `in` directly in loopback benches.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data   input  8  byte to transmit; sampled only on handshake.
- valid  input  1  producer has a byte on `data`.
- ready  output 1  transmitter can accept a byte this cycle.
- out    output 1  serial line; idles high.
- busy   output 1  high while a frame is on the line.
- done   output 1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, out=1, ready=1, busy=0, done=0, bit counter=0, baud counter=0. All registers are outputs of flops; no combinational path from `data` to `out`.
- Handshake: transfer occurs on a rising edge where valid=1 and ready=1.
  - That edge latches `data` into the shift register, enters START, and drives out=0, ready=0, busy=1.
  - valid while ready=0 is ignored; changes on `data` mid-frame do not affect the frame.
- States:
  - IDLE: out=1; ready=1.
  - START: out=0 for CLKS_PER_BIT cycles.
  - DATA: out=shift[0]; shift right every CLKS_PER_BIT cycles; 8 bits; bit counter 0..7.
  - STOP: out=1 for CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change.
  - Bit boundary occurs when the counter reaches CLKS_PER_BIT-1.
  - Counter width is $clog2(CLKS_PER_BIT).
- Frame length: exactly 10*CLKS_PER_BIT cycles from the handshake edge to the next possible start edge (80 cycles at default).
- End of frame, in the last STOP cycle:
  - done=1 and ready=1.
  - If valid=1 in that cycle, the handshake completes, the next edge enters START directly (no idle gap), and busy stays 1.
  - Otherwise the next edge enters IDLE with busy=0.
- Reset mid-frame: out returns to 1 immediately (asynchronous); the partial frame is abandoned. After reset release the next handshake sends a complete frame.
- Simultaneous reset deassertion and valid=1: the handshake is honoured on the first rising edge with reset=1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - out = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
- When undefined: no PARITY state or logic exists; frame is 10*CLKS_PER_BIT cycles.
- Must match the receiver's build configuration.

Decomposition:
- Shared package uart_pkg holds:
  - tx state enum (IDLE, START, DATA, PARITY, STOP)
  - UART_DATA_BITS=8
  - UART_IDLE_LEVEL=1, UART_START_LEVEL=0, UART_STOP_LEVEL=1
  - default CLKS_PER_BIT
- One natural sub-module: uart_baud_gen.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear, enable. Output: bit_tick.
  - Reusable by the receiver.

Test Plan:
- Reset hold then release, valid=0 for 50 cycles -> out=1, ready=1, busy=0, done=0 throughout.
- Send 0x55 at CLKS_PER_BIT=8 -> out: 0 for 8 cycles, then 1,0,1,0,1,0,1,0 each 8 cycles, then 1 for 8 cycles. done pulses at cycle 80; ready returns high at cycle 80.
- Back-to-back 0xCC, 0xFF, 0x33 with valid held high -> three contiguous frames totalling 240 cycles, no idle gap. Loopback through the receiver yields 0xCC, 0xFF, 0x33.
- valid=1 with data toggling 0x00/0xFF every cycle during a frame of 0xA5 -> line carries 0xA5 unchanged; no extra handshake occurs.
- Assert reset at cycle 35 of a 0x0F frame -> out=1 within the same cycle; ready=1 after release. A following 0x3C is sent as a full, correct frame.
- With UART_TX_PARITY_EN: 0x55 -> parity bit 0; 0x07 -> parity bit 1; frame is 88 cycles.
